// File: rtl/bexkat1Def.sv
// Shared bexkat1 definitions: instruction type codes, memory access size and
// memory-stage FSM state types.
package bexkat1Def;

  // Instruction type codes carried in ir[31:28]
  localparam logic [3:0] T_INH    = 4'd0;
  localparam logic [3:0] T_PUSH   = 4'd1;
  localparam logic [3:0] T_POP    = 4'd2;
  localparam logic [3:0] T_CMP    = 4'd3;
  localparam logic [3:0] T_MOV    = 4'd4;
  localparam logic [3:0] T_FP     = 4'd5;
  localparam logic [3:0] T_ALU    = 4'd6;
  localparam logic [3:0] T_INT    = 4'd7;
  localparam logic [3:0] T_LDI    = 4'd8;
  localparam logic [3:0] T_LOAD   = 4'd9;
  localparam logic [3:0] T_STORE  = 4'd10;
  localparam logic [3:0] T_BRANCH = 4'd11;
  localparam logic [3:0] T_JUMP   = 4'd12;

  typedef enum logic [1:0] {
    MEM_WORD = 2'd0,
    MEM_HALF = 2'd1,
    MEM_BYTE = 2'd2
  } memsize_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUS  = 2'd1,
    MS_DONE = 2'd2
  } memstate_t;

  // LOAD/STORE size field: 0 and 3 are both full words
  function automatic memsize_t ls_size(input logic [1:0] op);
    case (op)
      2'd1:    return MEM_HALF;
      2'd2:    return MEM_BYTE;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lanes.sv
// Big-endian byte-lane steering: byte select, store data replication and
// load data extraction (right-justified, zero-extended). Purely combinational.
module mem_lanes
  import bexkat1Def::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Lane select and data alignment; byte 0 of a word lives in bits 31:24
  always_comb begin
    sel_o   = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (size_i == MEM_BYTE) begin
      sel_o   = 4'b1000 >> addr_i;
      wdata_o = {4{wdata_i[7:0]}};
      case (addr_i)
        2'd0:    rdata_o = {24'h0, rdata_i[31:24]};
        2'd1:    rdata_o = {24'h0, rdata_i[23:16]};
        2'd2:    rdata_o = {24'h0, rdata_i[15:8]};
        default: rdata_o = {24'h0, rdata_i[7:0]};
      endcase
    end else if (size_i == MEM_HALF) begin
      // addr[0] is ignored: halfwords are forced onto a 2-byte boundary
      sel_o   = addr_i[1] ? 4'b0011 : 4'b1100;
      wdata_o = {2{wdata_i[15:0]}};
      rdata_o = addr_i[1] ? {16'h0, rdata_i[15:0]} : {16'h0, rdata_i[31:16]};
    end
  end

endmodule

// File: rtl/mem_access.sv
// bexkat1 memory-access pipeline stage. Performs LOAD/STORE/PUSH/POP over a
// single-master classic bus with big-endian byte lanes, holding upstream via
// stall_o while a bus cycle is outstanding.
// Optional bus watchdog: define BEXKAT1_MEM_TIMEOUT_EN to add the TIMEOUT
// parameter and the bus_err_o abort pulse.
module mem_access
  import bexkat1Def::*;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT = 16
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  input  logic [1:0]  sp_write_i,
  input  logic [31:0] sp_data_i,
  input  logic        stall_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  output logic [1:0]  sp_write_o,
  output logic [31:0] sp_data_o,
  output logic        stall_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i
`ifdef BEXKAT1_MEM_TIMEOUT_EN
  ,
  output logic        bus_err_o
`endif
);

  memstate_t   state_q, state_d;
  // Bus master registers (stb tracks cyc: one strobe per cycle)
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  // Access shape kept for load extraction, and read capture
  memsize_t    size_q, size_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        acked_q, acked_d;
  logic [31:0] rdata_q, rdata_d;
  // Instruction latched while the bus cycle runs
  logic [63:0] lat_ir_q, lat_ir_d;
  logic [31:0] lat_pc_q, lat_pc_d, lat_result_q, lat_result_d, lat_sp_data_q, lat_sp_data_d;
  logic [1:0]  lat_reg_write_q, lat_reg_write_d, lat_sp_write_q, lat_sp_write_d;
  // Registered stage outputs
  logic [63:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d, result_q, result_d, sp_data_q, sp_data_d;
  logic [1:0]  reg_write_q, reg_write_d, sp_write_q, sp_write_d;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d, err_q, err_d;
`endif

  // Decode of the incoming instruction
  logic [3:0]  typ, op;
  logic        dec_acc, dec_we;
  logic [31:0] dec_addr, dec_wdata;
  memsize_t    dec_size;

  assign typ = ir_i[31:28];
  assign op  = ir_i[27:24];

  // Classify the access: direction, address source, data source and size
  always_comb begin
    dec_acc   = 1'b0;
    dec_we    = 1'b0;
    dec_addr  = result_i;
    dec_wdata = reg_data1_i;
    dec_size  = MEM_WORD;
    case (typ)
      T_LOAD: begin
        dec_acc  = 1'b1;
        dec_size = ls_size(op[1:0]);
      end
      T_STORE: begin
        dec_acc  = 1'b1;
        dec_we   = 1'b1;
        dec_size = ls_size(op[1:0]);
      end
      T_PUSH: begin
        dec_acc  = 1'b1;
        dec_we   = 1'b1;
        dec_addr = sp_data_i;
        // Call-style pushes save the PC rather than a register
        if (op == 4'd1 || op == 4'd2) dec_wdata = pc_i;
      end
      T_POP: begin
        dec_acc  = 1'b1;
        dec_addr = sp_data_i - 32'd4;
      end
      default: ;
    endcase
  end

  // Lane logic sees the decoded access in IDLE and the latched one afterwards
  memsize_t    lane_size;
  logic [1:0]  lane_addr;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_rdata;

  assign lane_size = (state_q == MS_IDLE) ? dec_size : size_q;
  assign lane_addr = (state_q == MS_IDLE) ? dec_addr[1:0] : addr_lo_q;

  mem_lanes u_lanes (
    .size_i  (lane_size),
    .addr_i  (lane_addr),
    .wdata_i (dec_wdata),
    .rdata_i (bus_dat_i),
    .sel_o   (lane_sel),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  // Upstream must hold while an access is starting or in flight, and whenever
  // writeback is holding us
  assign stall_o = stall_i || (state_q == MS_BUS) || (state_q == MS_IDLE && dec_acc);

  // Next-state logic for the FSM, bus master and stage outputs
  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    we_d            = we_q;
    adr_d           = adr_q;
    sel_d           = sel_q;
    dat_d           = dat_q;
    size_d          = size_q;
    addr_lo_d       = addr_lo_q;
    acked_d         = acked_q;
    rdata_d         = rdata_q;
    lat_ir_d        = lat_ir_q;
    lat_pc_d        = lat_pc_q;
    lat_result_d    = lat_result_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_sp_write_d  = lat_sp_write_q;
    lat_sp_data_d   = lat_sp_data_q;
    ir_d            = ir_q;
    pc_d            = pc_q;
    result_d        = result_q;
    reg_write_d     = reg_write_q;
    sp_write_d      = sp_write_q;
    sp_data_d       = sp_data_q;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
    cnt_d           = cnt_q;
    abort_d         = abort_q;
    err_d           = 1'b0;
`endif
    case (state_q)
      MS_IDLE: begin
        if (!stall_i) begin
          if (dec_acc) begin
            state_d         = MS_BUS;
            cyc_d           = 1'b1;
            we_d            = dec_we;
            adr_d           = {dec_addr[31:2], 2'b00};
            sel_d           = lane_sel;
            dat_d           = lane_wdata;
            size_d          = dec_size;
            addr_lo_d       = dec_addr[1:0];
            acked_d         = 1'b0;
            lat_ir_d        = ir_i;
            lat_pc_d        = pc_i;
            lat_result_d    = result_i;
            lat_reg_write_d = reg_write_i;
            lat_sp_write_d  = sp_write_i;
            lat_sp_data_d   = sp_data_i;
            // Emit a bubble while the access runs so writeback never
            // sees the previous instruction twice
            ir_d            = '0;
            pc_d            = '0;
            result_d        = '0;
            reg_write_d     = '0;
            sp_write_d      = '0;
            sp_data_d       = '0;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
            cnt_d           = '0;
            abort_d         = 1'b0;
`endif
          end else begin
            ir_d        = ir_i;
            pc_d        = pc_i;
            result_d    = result_i;
            reg_write_d = reg_write_i;
            sp_write_d  = sp_write_i;
            sp_data_d   = sp_data_i;
          end
        end
      end
      MS_BUS: begin
        if (cyc_q) begin
          if (bus_ack_i) begin
            // End the bus cycle at once; completion may still wait on stall_i
            cyc_d   = 1'b0;
            acked_d = 1'b1;
            rdata_d = lane_rdata;
          end
`ifdef BEXKAT1_MEM_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cyc_d   = 1'b0;
            acked_d = 1'b1;
            abort_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        if (acked_d && !stall_i) begin
          state_d     = MS_DONE;
          ir_d        = lat_ir_q;
          pc_d        = lat_pc_q;
          result_d    = we_q ? lat_result_q : rdata_d;
          reg_write_d = lat_reg_write_q;
          sp_write_d  = lat_sp_write_q;
          sp_data_d   = lat_sp_data_q;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
          if (abort_d) begin
            result_d    = 32'hFFFF_FFFF;
            reg_write_d = 2'b00;
          end
`endif
        end
      end
      MS_DONE: begin
        // Upstream still presents the finished instruction this cycle;
        // it is consumed, so the next slot is a bubble
        if (!stall_i) begin
          state_d     = MS_IDLE;
          ir_d        = '0;
          pc_d        = '0;
          result_d    = '0;
          reg_write_d = '0;
          sp_write_d  = '0;
          sp_data_d   = '0;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any bus cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= MS_IDLE;
      cyc_q           <= 1'b0;
      we_q            <= 1'b0;
      adr_q           <= '0;
      sel_q           <= '0;
      dat_q           <= '0;
      size_q          <= MEM_WORD;
      addr_lo_q       <= '0;
      acked_q         <= 1'b0;
      rdata_q         <= '0;
      lat_ir_q        <= '0;
      lat_pc_q        <= '0;
      lat_result_q    <= '0;
      lat_reg_write_q <= '0;
      lat_sp_write_q  <= '0;
      lat_sp_data_q   <= '0;
      ir_q            <= '0;
      pc_q            <= '0;
      result_q        <= '0;
      reg_write_q     <= '0;
      sp_write_q      <= '0;
      sp_data_q       <= '0;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
      cnt_q           <= '0;
      abort_q         <= 1'b0;
      err_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      we_q            <= we_d;
      adr_q           <= adr_d;
      sel_q           <= sel_d;
      dat_q           <= dat_d;
      size_q          <= size_d;
      addr_lo_q       <= addr_lo_d;
      acked_q         <= acked_d;
      rdata_q         <= rdata_d;
      lat_ir_q        <= lat_ir_d;
      lat_pc_q        <= lat_pc_d;
      lat_result_q    <= lat_result_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_sp_write_q  <= lat_sp_write_d;
      lat_sp_data_q   <= lat_sp_data_d;
      ir_q            <= ir_d;
      pc_q            <= pc_d;
      result_q        <= result_d;
      reg_write_q     <= reg_write_d;
      sp_write_q      <= sp_write_d;
      sp_data_q       <= sp_data_d;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
      cnt_q           <= cnt_d;
      abort_q         <= abort_d;
      err_q           <= err_d;
`endif
    end
  end

  assign ir_o        = ir_q;
  assign pc_o        = pc_q;
  assign result_o    = result_q;
  assign reg_write_o = reg_write_q;
  assign sp_write_o  = sp_write_q;
  assign sp_data_o   = sp_data_q;
  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_adr_o   = adr_q;
  assign bus_sel_o   = sel_q;
  assign bus_dat_o   = dat_q;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
  assign bus_err_o   = err_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, randomized
// transactions against a byte-level reference model, and hand sequences for
// stall-across-ack, reset mid-cycle and (when compiled in) the bus watchdog.
module tb_mem_access;
  import bexkat1Def::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i, result_i, reg_data1_i, sp_data_i;
  logic [1:0]  reg_write_i, sp_write_i;
  logic        stall_i;
  logic [63:0] ir_o;
  logic [31:0] pc_o, result_o, sp_data_o;
  logic [1:0]  reg_write_o, sp_write_o;
  logic        stall_o, bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
`ifdef BEXKAT1_MEM_TIMEOUT_EN
  logic        bus_err_o;
`endif

  int tests = 0;
  int fails = 0;
  int txn   = 0;

  always #5 clk = ~clk;

`ifdef BEXKAT1_MEM_TIMEOUT_EN
  mem_access #(.TIMEOUT(16)) dut (
`else
  mem_access dut (
`endif
    .clk_i(clk), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i),
    .reg_data1_i(reg_data1_i), .reg_write_i(reg_write_i), .sp_write_i(sp_write_i),
    .sp_data_i(sp_data_i), .stall_i(stall_i), .ir_o(ir_o), .pc_o(pc_o),
    .result_o(result_o), .reg_write_o(reg_write_o), .sp_write_o(sp_write_o),
    .sp_data_o(sp_data_o), .stall_o(stall_o), .bus_cyc_o(bus_cyc_o),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i)
`ifdef BEXKAT1_MEM_TIMEOUT_EN
    , .bus_err_o(bus_err_o)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: treats the bus word as four big-endian byte slots and
  // derives lanes/data from the access width n and byte offset.
  task automatic model(input logic [3:0] typ, input logic [3:0] op,
                       input logic [31:0] result, input logic [31:0] rd1,
                       input logic [31:0] pc, input logic [31:0] spd,
                       input logic [31:0] rdata,
                       output logic acc, output logic we, output logic [31:0] adr,
                       output logic [3:0] sel, output logic [31:0] dat,
                       output logic [31:0] res);
    int n, off;
    logic [31:0] ea, src;
    acc = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; res = result;
    n = 4; ea = result; src = rd1;
    if (typ == T_LOAD || typ == T_STORE) begin
      acc = 1'b1;
      we  = (typ == T_STORE);
      n   = (op[1:0] == 2'd1) ? 2 : (op[1:0] == 2'd2) ? 1 : 4;
    end else if (typ == T_PUSH) begin
      acc = 1'b1; we = 1'b1; ea = spd;
      if (op == 4'd1 || op == 4'd2) src = pc;
    end else if (typ == T_POP) begin
      acc = 1'b1; ea = spd - 32'd4;
    end
    if (acc) begin
      off = int'(ea % 4);
      off = off - (off % n);
      adr = ea - (ea % 4);
      for (int k = 0; k < 4; k++) begin
        if (k >= off && k < off + n) sel[3-k] = 1'b1;
        dat[31-8*k -: 8] = 8'((src >> (8 * (n - 1 - (k % n)))) & 32'hFF);
      end
      if (!we) begin
        res = '0;
        for (int j = 0; j < n; j++)
          res = (res << 8) | ((rdata >> (8 * (3 - (off + j)))) & 32'hFF);
      end
    end
  endtask

  // One instruction through the stage; caller is at a negedge in IDLE
  task automatic do_txn(input logic [63:0] ir, input logic [31:0] pc,
                        input logic [31:0] result, input logic [31:0] rd1,
                        input logic [1:0] rw, input logic [1:0] spw,
                        input logic [31:0] spd, input logic [31:0] rdata, input int delay,
                        input logic eacc, input logic ewe, input logic [3:0] esel,
                        input logic [31:0] eadr, input logic [31:0] edat,
                        input logic [31:0] eres);
    txn++;
    ir_i = ir; pc_i = pc; result_i = result; reg_data1_i = rd1;
    reg_write_i = rw; sp_write_i = spw; sp_data_i = spd; stall_i = 1'b0;
    bus_ack_i = 1'b0; bus_dat_i = 32'h0;
    #1;
    chk("stall_decode", 64'(stall_o), 64'(eacc));
    if (eacc) begin
      @(negedge clk);
      chk("cyc", 64'(bus_cyc_o), 64'(1));
      chk("stb", 64'(bus_stb_o), 64'(1));
      chk("adr", 64'(bus_adr_o), 64'(eadr));
      chk("sel", 64'(bus_sel_o), 64'(esel));
      chk("we", 64'(bus_we_o), 64'(ewe));
      if (ewe) chk("wdat", 64'(bus_dat_o), 64'(edat));
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        chk("stall_bus", 64'(stall_o), 64'(1));
        chk("adr_hold", 64'(bus_adr_o), 64'(eadr));
      end
      bus_ack_i = 1'b1; bus_dat_i = rdata;
      @(negedge clk);
      bus_ack_i = 1'b0; bus_dat_i = 32'h0;
      chk("cyc_done", 64'(bus_cyc_o), 64'(0));
      chk("stall_done", 64'(stall_o), 64'(0));
    end else begin
      @(negedge clk);
      chk("cyc_idle", 64'(bus_cyc_o), 64'(0));
    end
    chk("result", 64'(result_o), 64'(eres));
    chk("ir", ir_o, ir);
    chk("pc", 64'(pc_o), 64'(pc));
    chk("reg_write", 64'(reg_write_o), 64'(rw));
    chk("sp_write", 64'(sp_write_o), 64'(spw));
    chk("sp_data", 64'(sp_data_o), 64'(spd));
    $display("[TB] txn %0d type %0d acc %0d adr %h sel %b result %h", txn,
             ir[31:28], eacc, eadr, esel, result_o);
    if (eacc) @(negedge clk);  // DONE -> IDLE
  endtask

  typedef struct {
    logic [3:0]  typ;
    logic [3:0]  op;
    logic [31:0] result, rd1, pc, spd, rdata;
    int          delay;
    logic        eacc;
    logic [3:0]  esel;
    logic [31:0] eadr, edat, eres;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [63:0] ir;
    logic [3:0]  typ, op;
    logic [31:0] result, rd1, pc, spd, rdata;
    logic        acc, we;
    logic [31:0] adr, dat, res;
    logic [3:0]  sel;

    //             typ      op    result        rd1           pc         spd        rdata         dly acc sel      adr           dat           res
    vecs[0]  = '{T_ALU,   4'd0, 32'h1234,     32'h0,        32'h100, 32'h0,    32'h0,        0, 0, 4'b0000, 32'h0,    32'h0,        32'h1234};
    vecs[1]  = '{T_STORE, 4'd2, 32'h1003,     32'hAB,       32'h104, 32'h0,    32'h0,        2, 1, 4'b0001, 32'h1000, 32'hABABABAB, 32'h1003};
    vecs[2]  = '{T_LOAD,  4'd1, 32'h2000,     32'h0,        32'h108, 32'h0,    32'hBEEF1234, 1, 1, 4'b1100, 32'h2000, 32'h0,        32'h0000BEEF};
    vecs[3]  = '{T_PUSH,  4'd1, 32'h55,       32'h0,        32'h400, 32'h7FFC, 32'h0,        0, 1, 4'b1111, 32'h7FFC, 32'h400,      32'h55};
    vecs[4]  = '{T_LOAD,  4'd2, 32'h3001,     32'h0,        32'h110, 32'h0,    32'h11223344, 0, 1, 4'b0100, 32'h3000, 32'h0,        32'h22};
    vecs[5]  = '{T_LOAD,  4'd1, 32'h3003,     32'h0,        32'h114, 32'h0,    32'h11223344, 3, 1, 4'b0011, 32'h3000, 32'h0,        32'h3344};
    vecs[6]  = '{T_STORE, 4'd1, 32'h4002,     32'h1234ABCD, 32'h118, 32'h0,    32'h0,        1, 1, 4'b0011, 32'h4000, 32'hABCDABCD, 32'h4002};
    vecs[7]  = '{T_STORE, 4'd3, 32'h5007,     32'hDEADBEEF, 32'h11C, 32'h0,    32'h0,        0, 1, 4'b1111, 32'h5004, 32'hDEADBEEF, 32'h5007};
    vecs[8]  = '{T_POP,   4'd0, 32'h77,       32'h0,        32'h120, 32'h8000, 32'h13579BDF, 2, 1, 4'b1111, 32'h7FFC, 32'h0,        32'h13579BDF};
    vecs[9]  = '{T_PUSH,  4'd0, 32'h66,       32'hA5A5A5A5, 32'h124, 32'h6000, 32'h0,        1, 1, 4'b1111, 32'h6000, 32'hA5A5A5A5, 32'h66};
    vecs[10] = '{T_LOAD,  4'd0, 32'h100,      32'h0,        32'h128, 32'h0,    32'h0F0F0F0F, 0, 1, 4'b1111, 32'h100,  32'h0,        32'h0F0F0F0F};
    vecs[11] = '{T_MOV,   4'd3, 32'hFACE,     32'h0,        32'h12C, 32'h0,    32'h0,        0, 0, 4'b0000, 32'h0,    32'h0,        32'hFACE};

    rst_i = 1'b1; stall_i = 1'b0; bus_ack_i = 1'b0; bus_dat_i = '0;
    ir_i = '0; pc_i = '0; result_i = '0; reg_data1_i = '0;
    reg_write_i = '0; sp_write_i = '0; sp_data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(result_o), 64'(0));
    chk("rst_ir", ir_o, 64'(0));
    chk("rst_reg_write", 64'(reg_write_o), 64'(0));
    chk("rst_cyc", 64'(bus_cyc_o), 64'(0));
    chk("rst_stall", 64'(stall_o), 64'(0));
    chk("rst_sel", 64'(bus_sel_o), 64'(0));
    rst_i = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      ir = {32'h0, vecs[i].typ, vecs[i].op, 24'h000123};
      do_txn(ir, vecs[i].pc, vecs[i].result, vecs[i].rd1, 2'(i), 2'(i >> 1),
             vecs[i].spd, vecs[i].rdata, vecs[i].delay, vecs[i].eacc,
             (vecs[i].typ == T_STORE || vecs[i].typ == T_PUSH),
             vecs[i].esel, vecs[i].eadr, vecs[i].edat, vecs[i].eres);
    end

    // Randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      typ    = 4'($urandom_range(0, 12));
      op     = (typ == T_PUSH) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      result = $urandom; rd1 = $urandom; pc = $urandom;
      spd    = $urandom; rdata = $urandom;
      ir     = {32'($urandom), typ, op, 24'($urandom)};
      model(typ, op, result, rd1, pc, spd, rdata, acc, we, adr, sel, dat, res);
      do_txn(ir, pc, result, rd1, 2'($urandom), 2'($urandom), spd, rdata,
             int'($urandom_range(0, 4)), acc, we, sel, adr, dat, res);
    end

    // POP with stall_i held across the ack
    txn++;
    ir_i = {32'h0, T_POP, 4'd0, 24'h0}; pc_i = 32'h200; result_i = 32'h0;
    reg_data1_i = 32'h0; reg_write_i = 2'b01; sp_write_i = 2'b10; sp_data_i = 32'h9000;
    @(negedge clk);
    chk("pop_adr", 64'(bus_adr_o), 64'(32'h8FFC));
    stall_i = 1'b1; bus_ack_i = 1'b1; bus_dat_i = 32'hCAFEBABE;
    @(negedge clk);
    bus_ack_i = 1'b0; bus_dat_i = 32'h0;
    chk("pop_cyc_after_ack", 64'(bus_cyc_o), 64'(0));
    chk("pop_stall_held", 64'(stall_o), 64'(1));
    chk("pop_frozen", 64'(result_o == 32'hCAFEBABE), 64'(0));
    repeat (2) begin
      @(negedge clk);
      chk("pop_stall_wait", 64'(stall_o), 64'(1));
      chk("pop_frozen_wait", 64'(result_o == 32'hCAFEBABE), 64'(0));
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("pop_result", 64'(result_o), 64'(32'hCAFEBABE));
    chk("pop_stall_done", 64'(stall_o), 64'(0));
    chk("pop_sp_write", 64'(sp_write_o), 64'(2'b10));
    $display("[TB] txn %0d POP under stall result %h", txn, result_o);
    @(negedge clk);

    // Reset asserted while a STORE is on the bus
    txn++;
    ir_i = {32'h0, T_STORE, 4'd0, 24'h0}; result_i = 32'hC000; reg_data1_i = 32'h12345678;
    reg_write_i = 2'b00; sp_write_i = 2'b00;
    @(negedge clk);
    chk("rstbus_cyc_before", 64'(bus_cyc_o), 64'(1));
    rst_i = 1'b1; ir_i = '0;
    @(negedge clk);
    chk("rstbus_cyc", 64'(bus_cyc_o), 64'(0));
    chk("rstbus_stb", 64'(bus_stb_o), 64'(0));
    chk("rstbus_result", 64'(result_o), 64'(0));
    chk("rstbus_stall", 64'(stall_o), 64'(0));
    $display("[TB] txn %0d reset during bus cycle cyc %b", txn, bus_cyc_o);
    rst_i = 1'b0;
    @(negedge clk);

`ifdef BEXKAT1_MEM_TIMEOUT_EN
    // Watchdog: LOAD that is never acknowledged
    txn++;
    ir_i = {32'h0, T_LOAD, 4'd0, 24'h0}; result_i = 32'hA000; reg_write_i = 2'b11;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("tmo_err_low", 64'(bus_err_o), 64'(0));
      chk("tmo_cyc", 64'(bus_cyc_o), 64'(1));
    end
    @(negedge clk);
    chk("tmo_err_pulse", 64'(bus_err_o), 64'(1));
    chk("tmo_result", 64'(result_o), 64'(32'hFFFFFFFF));
    chk("tmo_reg_write", 64'(reg_write_o), 64'(0));
    chk("tmo_cyc_drop", 64'(bus_cyc_o), 64'(0));
    @(negedge clk);
    chk("tmo_err_end", 64'(bus_err_o), 64'(0));
    $display("[TB] txn %0d watchdog abort", txn);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of the bexkat1 execute stage.
- Consumes the execute stage's registered outputs and performs data-memory access for LOAD/STORE/PUSH/POP over a single-master classic bus with byte lanes.
- Forwards the registered result, register-write and SP-write controls to writeback.
- Holds the upstream pipeline via stall_o while a bus cycle is outstanding.

Parameters:
- TIMEOUT, 16, bus-cycle watchdog limit in clocks; used only when the Optional Feature is compiled in.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- ir_i  in  64  instruction word from execute
- pc_i  in  32  PC from execute
- result_i  in  32  execute result; effective address for LOAD/STORE
- reg_data1_i  in  32  store/push data
- reg_write_i  in  2  register write enables
- sp_write_i  in  2  SP write enables
- sp_data_i  in  32  new SP value; address for PUSH/POP
- stall_i  in  1  downstream hold
- ir_o  out  64  registered instruction
- pc_o  out  32  registered PC
- result_o  out  32  load data (aligned/extended) or passthrough result
- reg_write_o  out  2  registered reg_write
- sp_write_o  out  2  registered sp_write
- sp_data_o  out  32  registered sp_data
- stall_o  out  1  hold upstream stages
- bus_cyc_o, bus_stb_o, bus_we_o  out  1 each  bus control
- bus_adr_o  out  32  word address (byte address with [1:0] forced to 0)
- bus_sel_o  out  4  byte lanes; bit3 = bits 31:24 (big-endian)
- bus_dat_o  out  32  write data
- bus_dat_i  in  32  read data
- bus_ack_i  in  1  cycle acknowledge
- bus_err_o  out  1  watchdog abort pulse; Optional Feature only

Behaviour:
- Reset: all outputs 0; state IDLE.
- Access classes, decoded from ir_i[31:28]:
  - T_LOAD: read at result_i.
  - T_STORE: write reg_data1_i at result_i.
  - T_PUSH op0: write reg_data1_i at sp_data_i.
  - T_PUSH op1/op2: write pc_i at sp_data_i.
  - T_POP: read at sp_data_i − 4.
  - All other types: no access.
- Access size, LOAD/STORE only, from ir_op[1:0]: 0 word, 1 halfword, 2 byte, 3 word. PUSH/POP are always word.
- Byte lanes:
  - Byte: sel = 4'b1000 >> addr[1:0].
  - Halfword: addr[1]=0 → 4'b1100, addr[1]=1 → 4'b0011.
  - Word: 4'b1111.
- Store data: replicated across lanes.
- Load data: byte/halfword right-justified and zero-extended.
- Misalignment: addr[0] is ignored for halfword; addr[1:0] is ignored for word. No trap.
- FSM states:
  - IDLE, no access and no stall_i: register all inputs to outputs in one cycle; latency 1.
  - IDLE, access decoded and no stall_i: go to BUS. Drive cyc/stb, adr/sel/we/dat from inputs, latch ir/pc/sp/reg_write internally. stall_o = 1 combinationally in the same cycle.
  - BUS: hold all bus outputs stable until bus_ack_i. On ack, capture data (reads) and go to DONE. stall_o = 1 throughout.
  - DONE: drop cyc/stb. Present the latched instruction on outputs, result_o = load data (reads) or result_i latched (writes). stall_o = 0. Go to IDLE.
- Minimum access latency is 3 clocks (ack in the first BUS cycle).
- Ack arriving on the same clock the cycle is started is not possible: stb first rises entering BUS.
- stall_i: outputs hold their values. In BUS, the bus cycle continues; an ack is captured, and completion to DONE waits until stall_i drops.
- No stall_i and no access: reg_write_o etc. follow the inputs. An instruction is never duplicated, because stall_o freezes upstream.
- Reset mid-cycle: cyc/stb drop in the same clock; the transaction is abandoned; outputs go to 0.

Optional Feature:
- Macro BEXKAT1_MEM_TIMEOUT_EN.
- With the macro: a counter runs in BUS. When the counter reaches TIMEOUT with no ack, abort: drop cyc/stb, pulse bus_err_o for 1 cycle, go to DONE with result_o = 32'hFFFFFFFF and reg_write_o forced to 0.
- Without the macro: BUS waits indefinitely; bus_err_o is absent.

Decomposition:
- Add to package bexkat1Def: memsize_t {MEM_WORD, MEM_HALF, MEM_BYTE} and memstate_t {MS_IDLE, MS_BUS, MS_DONE}.
- Reuse existing T_* type constants.
- One combinational sub-module, mem_lanes: inputs size + addr[1:0] + write data + read data; outputs sel, replicated write data, extracted read data.

Test Plan:
- T_ALU passthrough, result_i=32'h1234, reg_write_i=2'b01 → result_o=32'h1234 next cycle, stall_o never asserted, bus_cyc_o=0.
- T_STORE byte, result_i=32'h1003, reg_data1_i=32'hAB, ack after 2 cycles → bus_sel_o=4'b0001, bus_adr_o=32'h1000, bus_dat_o=32'hABABABAB, bus_we_o=1, stall_o high until DONE.
- T_LOAD halfword, result_i=32'h2000, bus_dat_i=32'hBEEF1234 → result_o=32'h0000BEEF, sel=4'b1100.
- T_PUSH op1, sp_data_i=32'h7FFC, pc_i=32'h400 → write 32'h400 at 32'h7FFC, sel=4'b1111, sp_write_o propagated.
- stall_i high across ack during T_POP → data captured, outputs frozen, result_o valid the cycle after stall_i drops. Separately, rst_i asserted in BUS → cyc/stb 0 next clock.
- BEXKAT1_MEM_TIMEOUT_EN, TIMEOUT=16, no ack → bus_err_o pulses after 16 cycles, result_o=32'hFFFFFFFF, reg_write_o=0.
